ex_issue_ctrl: RTL

- Execute-stage issue controller. Sits directly upstream of the ALU/divider block and downstream of the decoder (ID).
- Registers one decoded instruction and drives the ALU/divider operator and operands. For divides it holds `enable` until the divider signals `ready`.
- Captures the result into a writeback register with a valid/ready handshake to WB. Branch decisions go out as a separate one-cycle pulse.
- Only one instruction is in flight at a time. ID is back-pressured through `id_ready_o`.

---
 rtl/ex_issue_ctrl_pkg.sv | 52 +++++
 rtl/ex_issue_ctrl_wb_reg.sv | 49 ++++
 rtl/ex_issue_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ex_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ex_issue_ctrl_pkg
// Shared ALU package for the execute stage: operation codes, execute-stage
// state encoding, the registered-operation record and a small helper used to
// decide whether the writeback slot can take a new result.
// -----------------------------------------------------------------------------
package ex_issue_ctrl_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_EQ   = 4'd8,
        ALU_NE   = 4'd9,
        ALU_LT   = 4'd10,
        ALU_GE   = 4'd11,
        ALU_DIV  = 4'd12,
        ALU_DIVU = 4'd13,
        ALU_REM  = 4'd14,
        ALU_REMU = 4'd15
    } alu_opcode_e;

    // Execute-stage states, kept as plain 2-bit constants so older code that
    // compares against raw encodings keeps working.
    typedef logic [1:0] ex_state_e;
    localparam ex_state_e IDLE     = 2'd0;
    localparam ex_state_e EXEC     = 2'd1;
    localparam ex_state_e DIV_WAIT = 2'd2;

    // One decoded instruction as held in the execute stage.
    typedef struct packed {
        alu_opcode_e               opcode;
        logic [XLEN_DEFAULT-1:0]   operand_a;
        logic [XLEN_DEFAULT-1:0]   operand_b;
        logic [4:0]                rd;
        logic                      is_div;
        logic                      is_branch;
    } ex_op_t;

    // The writeback slot is usable when it is empty or being drained this cycle.
    function automatic logic slot_free_f(input logic wb_valid, input logic wb_ready);
        return (!wb_valid) || wb_ready;
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_wb_reg.sv
// -----------------------------------------------------------------------------
// ex_wb_reg
// Writeback register between the execute stage and WB. Holds one result with
// a valid/ready handshake. A capture in the same cycle as a consume wins and
// leaves the register valid with the new data. There is deliberately no flush
// input: a result that reached this register is always delivered.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   capture         load capture_result/capture_rd and set valid
//   capture_result  result to load
//   capture_rd      destination register to load
//   consume         WB takes the current result (wb_ready)
//   valid           register holds a result
//   result, rd_addr held result and destination, stable while not consumed
// -----------------------------------------------------------------------------
module ex_wb_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            capture,
    input  logic [XLEN-1:0] capture_result,
    input  logic [4:0]      capture_rd,
    input  logic            consume,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_addr
);

    // Valid flag and payload; data only changes on capture so it stays stable
    // while WB is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            result  <= '0;
            rd_addr <= 5'd0;
        end else if (capture) begin
            valid   <= 1'b1;
            result  <= capture_result;
            rd_addr <= capture_rd;
        end else if (consume) begin
            valid   <= 1'b0;
        end else begin
            valid   <= valid;
        end
    end

endmodule

// File: rtl/ex_issue_ctrl.sv
// -----------------------------------------------------------------------------
// ex_issue_ctrl
// Execute-stage issue controller between the decoder and the ALU/divider.
// Registers one instruction at a time, drives the ALU operator/operands, holds
// the divider enable until the divider reports ready, and captures results
// into a writeback register. Branches produce a one-cycle decision pulse and
// no writeback.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_*                         decoded instruction and handshake from ID
//   flush_i                      kill the in-flight instruction
//   alu_operator_o/operand_*_o   registered operation to the ALU/divider
//   alu_enable_o                 divider enable (high for the whole divide)
//   alu_ex_ready_o               EX can accept a divider result
//   alu_result_i/cmp_i/ready_i   ALU/divider responses
//   wb_*                         writeback handshake and payload
//   branch_valid_o/taken_o       branch decision pulse
//   div_busy_cycles_o            saturating count of divide-wait cycles
// Operands are carried in the shared ex_op_t record, so XLEN must not exceed
// XLEN_DEFAULT.
// -----------------------------------------------------------------------------
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  alu_opcode_e       id_operator_i,
    input  logic [XLEN-1:0]   id_operand_a_i,
    input  logic [XLEN-1:0]   id_operand_b_i,
    input  logic [4:0]        id_rd_addr_i,
    input  logic              id_is_div_i,
    input  logic              id_is_branch_i,
    input  logic              flush_i,
    output alu_opcode_e       alu_operator_o,
    output logic [XLEN-1:0]   alu_operand_a_o,
    output logic [XLEN-1:0]   alu_operand_b_o,
    output logic              alu_enable_o,
    output logic              alu_ex_ready_o,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic              alu_cmp_i,
    input  logic              alu_ready_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [XLEN-1:0]   wb_result_o,
    output logic [4:0]        wb_rd_addr_o,
    output logic              branch_valid_o,
    output logic              branch_taken_o,
    output logic [CNT_W-1:0]  div_busy_cycles_o
);

    ex_state_e          state;
    ex_op_t             op;
    logic               slot_free;
    logic               accept;
    logic               exec_wb;
    logic               div_done;
    logic               capture;
    logic               branch_valid;
    logic               branch_taken;
    logic [CNT_W-1:0]   busy_cnt;

    assign slot_free = slot_free_f(wb_valid_o, wb_ready_i);
    assign id_ready_o = (state == IDLE) && slot_free && !flush_i;
    assign accept = id_valid_i && id_ready_o;

    // is_div is never set while in EXEC; the extra term keeps a corrupted
    // record from producing a spurious single-cycle writeback.
    assign exec_wb  = (state == EXEC) && !op.is_branch && !op.is_div;
    assign div_done = (state == DIV_WAIT) && alu_ready_i && slot_free;

    // A flush in the same cycle as completion discards the result.
    assign capture = !flush_i && (exec_wb || div_done);

    assign alu_enable_o   = (state == DIV_WAIT);
    assign alu_ex_ready_o = (state != DIV_WAIT) || slot_free;

    assign alu_operator_o    = op.opcode;
    assign alu_operand_a_o   = XLEN'(op.operand_a);
    assign alu_operand_b_o   = XLEN'(op.operand_b);
    assign branch_valid_o    = branch_valid;
    assign branch_taken_o    = branch_taken;
    assign div_busy_cycles_o = busy_cnt;

    // Execute-stage sequencing: one instruction in flight, flush returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= id_is_div_i ? DIV_WAIT : EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    state <= IDLE;
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        state <= IDLE;
                    end else begin
                        state <= DIV_WAIT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Operation register; held unchanged for the whole EXEC/DIV_WAIT period.
    always_ff @(posedge clk) begin
        if (rst) begin
            op <= '0;
        end else if (accept) begin
            op.opcode    <= id_operator_i;
            op.operand_a <= XLEN_DEFAULT'(id_operand_a_i);
            op.operand_b <= XLEN_DEFAULT'(id_operand_b_i);
            op.rd        <= id_rd_addr_i;
            op.is_div    <= id_is_div_i;
            op.is_branch <= id_is_branch_i;
        end else begin
            op <= op;
        end
    end

    // Branch decision pulse, one cycle after the branch's EXEC cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            branch_valid <= (state == EXEC) && op.is_branch;
            branch_taken <= (state == EXEC) && op.is_branch && alu_cmp_i;
        end
    end

    // Divider busy counter, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_cnt <= '0;
        end else if ((state == DIV_WAIT) && (busy_cnt != {CNT_W{1'b1}})) begin
            busy_cnt <= busy_cnt + CNT_W'(1);
        end else begin
            busy_cnt <= busy_cnt;
        end
    end

    ex_wb_reg #(
        .XLEN(XLEN)
    ) u_wb_reg (
        .clk            (clk),
        .rst            (rst),
        .capture        (capture),
        .capture_result (alu_result_i),
        .capture_rd     (op.rd),
        .consume        (wb_ready_i),
        .valid          (wb_valid_o),
        .result         (wb_result_o),
        .rd_addr        (wb_rd_addr_o)
    );

endmodule
